// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch, fixed or jittered latency.
// Define IMEM_RAND_DELAY_EN to add 0..3 cycles of LFSR-driven extra latency.
module imem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_inst,
    output logic        rsp_err,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam logic [31:0] EBREAK  = 32'h0010_0073;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [4:0]  cnt_init;
    logic [31:0] addr_q;
    logic [31:0] mem [DEPTH];

    logic [29:0] rd_off;
    logic        rd_err;
    logic [29:0] wr_off;
    logic        wr_hit;

    // Word offsets from the base; wrap below base is caught by the compare.
    assign rd_off = addr_q[31:2] - BASE_ADDR[31:2];
    assign rd_err = (addr_q[1:0] != 2'b00)
                 || (addr_q < BASE_ADDR)
                 || (rd_off >= DEPTH_W);

    assign wr_off = wr_addr[31:2] - BASE_ADDR[31:2];
    assign wr_hit = wr_en
                 && (wr_addr >= BASE_ADDR)
                 && (wr_off < DEPTH_W);

`ifdef IMEM_RAND_DELAY_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign cnt_init = 5'(LATENCY - 1) + {3'b000, lfsr[1:0]};
`else
    assign cnt_init = 5'(LATENCY - 1);
`endif

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);

    // Program storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_off[AW-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 5'd0;
            addr_q   <= 32'd0;
            rsp_inst <= 32'd0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        cnt    <= cnt_init;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 5'd0) begin
                        rsp_inst <= rd_err ? EBREAK : mem[rd_off[AW-1:0]];
                        rsp_err  <= rd_err;
                        state    <= S_RESP;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Randomized self-checking bench for imem_responder against a word-array model.
// Works with or without IMEM_RAND_DELAY_EN defined.
module tb_imem_responder;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          D      = 4096;
    localparam int          L      = 2;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_inst;
    logic        rsp_err;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = 32'd0;
    logic [31:0] wr_data = 32'd0;
    logic [3:0]  wr_strb = 4'd0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_cyc = 0;

    logic [31:0] ref_mem [int];
    int          pl [$];

    imem_responder #(
        .BASE_ADDR(BASE),
        .DEPTH(D),
        .LATENCY(L),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_inst(rsp_inst),
        .rsp_err(rsp_err),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_strb(wr_strb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && ((off >>> 2) < D);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) >>> 2);
    endfunction

    task automatic expect_of(input logic [31:0] a, output logic [31:0] inst, output logic err);
        if (a[1:0] != 2'b00 || !in_range(a)) begin
            inst = EBREAK;
            err  = 1'b1;
        end else begin
            inst = ref_mem.exists(idx_of(a)) ? ref_mem[idx_of(a)] : 32'hxxxx_xxxx;
            err  = 1'b0;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        @(negedge clk);
        wr_en = 1'b0;
        if (in_range(a)) begin
            w = ref_mem.exists(idx_of(a)) ? ref_mem[idx_of(a)] : 32'd0;
            for (int b = 0; b < 4; b++)
                if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            ref_mem[idx_of(a)] = w;
        end
    endtask

    task automatic start_req(input logic [31:0] a);
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = a;
        @(posedge clk);
        #1;
        hs_cyc    = cyc;
        req_valid = 1'b0;
        req_addr  = $urandom;
    endtask

    task automatic finish_req(input logic [31:0] ei, input logic ee, input int hold);
        int guard;
        int lat;
        guard = 0;
        while (!rsp_valid && guard < 40) begin
            chk("req_ready_busy", req_ready, 0);
            @(posedge clk);
            #1;
            guard++;
        end
        if (!rsp_valid) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        lat = cyc - hs_cyc;
`ifdef IMEM_RAND_DELAY_EN
        chk("latency_range", 32'((lat >= L) && (lat <= L + 3)), 1);
`else
        chk("latency", lat, L);
`endif
        for (int h = 0; h <= hold; h++) begin
            chk("rsp_valid_hold", rsp_valid, 1);
            chk("rsp_inst", rsp_inst, ei);
            chk("rsp_err", rsp_err, ee);
            chk("req_ready_resp", req_ready, 0);
            if (h < hold) begin
                @(posedge clk);
                #1;
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("req_ready_back", req_ready, 1);
    endtask

    task automatic do_fetch(input logic [31:0] a, input int hold);
        logic [31:0] ei;
        logic        ee;
        expect_of(a, ei, ee);
        start_req(a);
        finish_req(ei, ee, hold);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ei;
        logic        ee;
        int          g;
        int          k;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_inst", rsp_inst, 0);
        chk("rst_rsp_err", rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_write(BASE, 32'h0000_0413, 4'hF);
        do_fetch(BASE, 0);
        do_fetch(BASE, 5);

        do_fetch(32'h8000_0002, 0);
        do_fetch(32'h8000_4000, 1);
        do_fetch(32'h7FFF_FFFC, 0);

        pl.push_back(0);
        pl.push_back(D - 1);
        do_write(BASE + 32'((D - 1) * 4), 32'hCAFE_F00D, 4'hF);
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(1, D - 2);
            pl.push_back(k);
            do_write(BASE + 32'(k * 4), $urandom, 4'hF);
        end
        do_fetch(BASE + 32'((D - 1) * 4), 0);

        do_write(BASE + 32'(3 * 4), 32'h1357_9BDF, 4'hF);
        do_write(BASE + 32'((D + 3) * 4), 32'hDEAD_BEEF, 4'hF);
        do_fetch(BASE + 32'(3 * 4), 0);

        do_write(BASE + 32'(5 * 4), 32'h1234_5678, 4'hF);
        start_req(BASE + 32'(5 * 4));
        do_write(BASE + 32'(5 * 4), 32'hFFFF_FFFF, 4'b0011);
        expect_of(BASE + 32'(5 * 4), ei, ee);
        finish_req(ei, ee, 0);
        chk("merge_value", ei, 32'h1234_FFFF);

`ifndef IMEM_RAND_DELAY_EN
        expect_of(BASE + 32'(5 * 4), ei, ee);
        start_req(BASE + 32'(5 * 4));
        repeat (L - 1) @(posedge clk);
        do_write(BASE + 32'(5 * 4), 32'hAAAA_0000, 4'b1100);
        finish_req(ei, ee, 0);
        do_fetch(BASE + 32'(5 * 4), 0);
`endif

        start_req(BASE);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_wait_valid", rsp_valid, 0);
        chk("rst_wait_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_valid", rsp_valid, 0);
            chk("post_rst_ready", req_ready, 1);
        end

        start_req(BASE);
        g = 0;
        while (!rsp_valid && g < 20) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("resp_reached", rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_resp_valid", rsp_valid, 0);
        chk("rst_resp_inst", rsp_inst, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("post_rst2_valid", rsp_valid, 0);
        end
        do_fetch(BASE, 0);

        for (int i = 0; i < 100; i++) begin
            k = $urandom_range(0, 9);
            if (k == 0)
                do_fetch(BASE + 32'(pl[$urandom_range(0, pl.size() - 1)] * 4) + 32'($urandom_range(1, 3)), 0);
            else if (k == 1)
                do_fetch(BASE - 32'(4 * $urandom_range(1, 64)), $urandom_range(0, 2));
            else if (k == 2)
                do_fetch(BASE + 32'(4 * (D + $urandom_range(0, 1000))), 0);
            else begin
                g = pl[$urandom_range(0, pl.size() - 1)];
                if (k == 3)
                    do_write(BASE + 32'(g * 4), $urandom, 4'($urandom_range(1, 15)));
                do_fetch(BASE + 32'(g * 4), $urandom_range(0, 3));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
